// File: rtl/debug_run_ctrl_if.sv
// Signal bundle between the debug run controller and the UART, instruction memory and pipeline.
// Handshakes: i_rx_valid is a one-cycle pulse that is always accepted (there is no ready);
// o_tx_start is a one-cycle pulse raised only in a cycle after i_tx_busy was sampled low.
interface debug_run_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        i_rx_data;
  logic              i_rx_valid;
  logic              i_tx_busy;
  logic [7:0]        o_tx_data;
  logic              o_tx_start;
  logic              o_imem_wr_en;
  logic [ADDR_W-1:0] o_imem_wr_addr;
  logic [7:0]        o_imem_wr_data;
  logic              i_halt_wb;
  logic              o_mips_en;
  logic              o_mips_rst;
  logic [2:0]        o_state;
  logic [31:0]       o_cycle_cnt;
  logic [ADDR_W-2:0] o_load_words;
  logic              o_load_ovf;

  modport master (
    input  i_rx_data, i_rx_valid, i_tx_busy, i_halt_wb,
    output o_tx_data, o_tx_start, o_imem_wr_en, o_imem_wr_addr, o_imem_wr_data,
           o_mips_en, o_mips_rst, o_state, o_cycle_cnt, o_load_words, o_load_ovf
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_tx_busy, i_halt_wb,
    input  o_tx_data, o_tx_start, o_imem_wr_en, o_imem_wr_addr, o_imem_wr_data,
           o_mips_en, o_mips_rst, o_state, o_cycle_cnt, o_load_words, o_load_ovf
  );
endinterface

// File: rtl/debug_run_ctrl.sv
// Debug sequencer for the MIPS core: UART command decode, program load, RUN/STEP gating
// of the pipeline and reporting of the executed-cycle count over the UART.
module debug_run_ctrl #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF,
  parameter logic [7:0]  CMD_LOAD  = 8'h4C,
  parameter logic [7:0]  CMD_RUN   = 8'h52,
  parameter logic [7:0]  CMD_STEP  = 8'h53
) (
  input logic clk,
  input logic rst,
  debug_run_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LOAD = 3'd1, S_RUN = 3'd2, S_STEP = 3'd3, S_REPORT = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic [ADDR_W-2:0] words_q, words_d;
  logic [31:0]       window_q, window_d, cnt_q, cnt_d;
  logic [7:0]        wr_data_q, wr_data_d, tx_data_q, tx_data_d;
  logic [2:0]        tx_cnt_q, tx_cnt_d;
  logic              ovf_q, ovf_d, wr_en_q, wr_en_d, tx_start_q, tx_start_d;
  logic              skip_q, skip_d, pulse_q, pulse_d, en_q, en_d, mrst_q, mrst_d;

  logic [31:0] word_next;
  logic        halt_hit, at_end, halt_seen;

  assign word_next = {window_q[23:0], bus.i_rx_data};
  assign halt_hit  = (addr_q[1:0] == 2'd3) && (word_next == HALT_WORD);
  assign at_end    = (addr_q == ADDR_MAX);
  // halt_wb is only meaningful while the pipeline is actually enabled
  assign halt_seen = en_q && bus.i_halt_wb;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wr_addr_q  <= '0;
      words_q    <= '0;
      window_q   <= '0;
      cnt_q      <= '0;
      wr_data_q  <= '0;
      tx_data_q  <= '0;
      tx_cnt_q   <= '0;
      ovf_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      tx_start_q <= 1'b0;
      skip_q     <= 1'b0;
      pulse_q    <= 1'b0;
      en_q       <= 1'b0;
      mrst_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wr_addr_q  <= wr_addr_d;
      words_q    <= words_d;
      window_q   <= window_d;
      cnt_q      <= cnt_d;
      wr_data_q  <= wr_data_d;
      tx_data_q  <= tx_data_d;
      tx_cnt_q   <= tx_cnt_d;
      ovf_q      <= ovf_d;
      wr_en_q    <= wr_en_d;
      tx_start_q <= tx_start_d;
      skip_q     <= skip_d;
      pulse_q    <= pulse_d;
      en_q       <= en_d;
      mrst_q     <= mrst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_rx_valid) begin
          if (bus.i_rx_data == CMD_LOAD)      state_d = S_LOAD;
          else if (bus.i_rx_data == CMD_RUN)  state_d = S_RUN;
          else if (bus.i_rx_data == CMD_STEP) state_d = S_STEP;
        end
      end
      S_LOAD:   if (bus.i_rx_valid && (halt_hit || at_end)) state_d = S_IDLE;
      S_RUN:    if (halt_seen) state_d = S_REPORT;
      S_STEP: begin
        if (halt_seen) state_d = S_REPORT;
        else if (bus.i_rx_valid && bus.i_rx_data == CMD_RUN) state_d = S_RUN;
      end
      S_REPORT: if (!skip_q && !bus.i_tx_busy && tx_cnt_q == 3'd4) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d     = addr_q;
    wr_addr_d  = wr_addr_q;
    words_d    = words_q;
    window_d   = window_q;
    cnt_d      = cnt_q;
    wr_data_d  = wr_data_q;
    tx_data_d  = tx_data_q;
    tx_cnt_d   = tx_cnt_q;
    ovf_d      = ovf_q;
    skip_d     = skip_q;
    wr_en_d    = 1'b0;
    tx_start_d = 1'b0;
    pulse_d    = 1'b0;

    if (en_q && cnt_q != 32'hFFFFFFFF) cnt_d = cnt_q + 32'd1;

    case (state_q)
      S_IDLE: begin
        if (bus.i_rx_valid) begin
          if (bus.i_rx_data == CMD_LOAD) begin
            addr_d   = '0;
            words_d  = '0;
            ovf_d    = 1'b0;
            window_d = '0;
          end else if (bus.i_rx_data == CMD_RUN) begin
            cnt_d = '0;
          end else if (bus.i_rx_data == CMD_STEP) begin
            cnt_d   = '0;
            pulse_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (bus.i_rx_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = bus.i_rx_data;
          window_d  = word_next;
          if (addr_q[1:0] == 2'd3) words_d = words_q + 1'b1;
          if (!halt_hit) begin
            if (at_end) ovf_d  = 1'b1;
            else        addr_d = addr_q + 1'b1;
          end
        end
      end
      S_STEP: begin
        if (bus.i_rx_valid && !halt_seen && bus.i_rx_data == CMD_STEP) pulse_d = 1'b1;
      end
      S_REPORT: begin
        // one dead cycle after each start lets the UART raise busy before it is checked again
        if (skip_q) begin
          skip_d = 1'b0;
        end else if (!bus.i_tx_busy && tx_cnt_q != 3'd4) begin
          tx_start_d = 1'b1;
          skip_d     = 1'b1;
          tx_cnt_d   = tx_cnt_q + 3'd1;
          case (tx_cnt_q[1:0])
            2'd0:    tx_data_d = cnt_q[31:24];
            2'd1:    tx_data_d = cnt_q[23:16];
            2'd2:    tx_data_d = cnt_q[15:8];
            default: tx_data_d = cnt_q[7:0];
          endcase
        end
      end
      default: ;
    endcase

    if (state_q != S_REPORT && state_d == S_REPORT) begin
      tx_cnt_d = '0;
      skip_d   = 1'b0;
    end

    en_d   = (state_d == S_RUN) || (state_d == S_STEP && pulse_d);
    mrst_d = (state_d == S_IDLE);
  end

  assign bus.o_state        = state_q;
  assign bus.o_mips_en      = en_q;
  assign bus.o_mips_rst     = mrst_q;
  assign bus.o_cycle_cnt    = cnt_q;
  assign bus.o_imem_wr_en   = wr_en_q;
  assign bus.o_imem_wr_addr = wr_addr_q;
  assign bus.o_imem_wr_data = wr_data_q;
  assign bus.o_tx_start     = tx_start_q;
  assign bus.o_tx_data      = tx_data_q;
  assign bus.o_load_words   = words_q;
  assign bus.o_load_ovf     = ovf_q;
endmodule
